// File: rtl/dac_spi_tx_if.sv
`default_nettype none
// ============================================================================
// Interface : dac_spi_tx_if
// Purpose   : Core-side strobe/data and DAC pin bundle for dac_spi_tx.
// Revision  : 1.0  initial release
// ============================================================================
interface dac_spi_tx_if;
  logic        start;
  logic [31:0] wdata;
  logic        dac_sclk;
  logic        dac_cs_n;
  logic        dac_mosi;
  logic        busy;
  logic        done;
  logic        overrun;

  // Core side: issues samples, observes status and pins
  modport master (
    output start, wdata,
    input  dac_sclk, dac_cs_n, dac_mosi, busy, done, overrun
  );

  // Transmitter side
  modport slave (
    input  start, wdata,
    output dac_sclk, dac_cs_n, dac_mosi, busy, done, overrun
  );
endinterface
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module    : dac_spi_tx
// Purpose   : SPI mode-0 transmitter sending {CMD, sample} frames to a DAC,
//             with a one-deep pending buffer for back-to-back samples.
// Revision  : 1.0  initial release
// ============================================================================
module dac_spi_tx #(
  parameter int                 DATA_W  = 12,
  parameter int                 CMD_W   = 4,
  parameter logic [CMD_W-1:0]   CMD     = 4'b0011,
  parameter int                 CLK_DIV = 4
) (
  input  wire logic     clock,
  input  wire logic     nReset,
  dac_spi_tx_if.slave   bus
);

  localparam int FRAME_W = CMD_W + DATA_W;
  localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_TRAIL = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BIT_W-1:0]   bitcnt;
  logic [FRAME_W-1:0] shreg;
  logic [DATA_W-1:0]  pend_data;
  logic               pend_full;
  logic               sclk_q, cs_n_q, mosi_q, busy_q, done_q, overrun_q;

  logic [FRAME_W-1:0] new_frame;
  logic [FRAME_W-1:0] gap_frame;
  logic               cnt_end;
  logic               gap_end;
  logic               gap_direct;
  logic               capture;
  logic               overwrite;

  assign new_frame  = {CMD, bus.wdata[DATA_W-1:0]};
  // Pending sample takes priority at the end of the gap; a start landing in
  // that same cycle with nothing pending is launched directly.
  assign gap_frame  = pend_full ? {CMD, pend_data} : new_frame;
  assign cnt_end    = (cnt == CNT_LAST);
  assign gap_end    = (state == S_GAP) && cnt_end;
  assign gap_direct = gap_end && !pend_full && bus.start;
  assign capture    = bus.start && (state != S_IDLE) && !gap_direct;
  // A full buffer being drained by the gap this cycle is not an overwrite.
  assign overwrite  = bus.start && (state != S_IDLE) && pend_full && !gap_end;

  // Upper register bits carry no DAC information.
  generate
    if (DATA_W < 32) begin : g_unused_hi
      wire unused_hi = ^bus.wdata[31:DATA_W];
    end
  endgenerate

  // Frame sequencer, divider, pending buffer and all registered pin outputs
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      pend_data <= '0;
      pend_full <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= overwrite;

      if (capture) begin
        pend_data <= bus.wdata[DATA_W-1:0];
        pend_full <= 1'b1;
      end else if (gap_end && pend_full) begin
        pend_full <= 1'b0;
      end

      // Every non-idle state ends when the divider wraps
      if (state != S_IDLE) begin
        cnt <= cnt_end ? '0 : cnt + CNT_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            shreg  <= new_frame;
            bitcnt <= '0;
            cnt    <= '0;
            cs_n_q <= 1'b0;
            mosi_q <= new_frame[FRAME_W-1];
            busy_q <= 1'b1;
            state  <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (cnt_end) begin
            sclk_q <= 1'b1;
            state  <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (cnt_end) begin
            sclk_q <= 1'b0;
            if (bitcnt == BIT_LAST) begin
              state <= S_TRAIL;
            end else begin
              shreg  <= shreg << 1;
              mosi_q <= shreg[FRAME_W-2];
              bitcnt <= bitcnt + BIT_W'(1);
              state  <= S_LOW;
            end
          end
        end
        S_LOW: begin
          if (cnt_end) begin
            sclk_q <= 1'b1;
            state  <= S_HIGH;
          end
        end
        S_TRAIL: begin
          if (cnt_end) begin
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_end) begin
            if (pend_full || bus.start) begin
              shreg  <= gap_frame;
              bitcnt <= '0;
              cs_n_q <= 1'b0;
              mosi_q <= gap_frame[FRAME_W-1];
              state  <= S_LEAD;
            end else begin
              busy_q <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          sclk_q <= 1'b0;
          cs_n_q <= 1'b1;
          mosi_q <= 1'b0;
          busy_q <= pend_full;
        end
      endcase
    end
  end

  assign bus.dac_sclk = sclk_q;
  assign bus.dac_cs_n = cs_n_q;
  assign bus.dac_mosi = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module    : tb_dac_spi_tx
// Purpose   : Self-checking bench for dac_spi_tx (CLK_DIV=4 and CLK_DIV=1).
// Revision  : 1.0  initial release
// ============================================================================
module tb_dac_spi_tx;

  logic clock  = 1'b0;
  logic nReset = 1'b1;

  always #5 clock = ~clock;

  dac_spi_tx_if bus0 ();
  dac_spi_tx_if bus1 ();

  dac_spi_tx #(.CLK_DIV(4)) u_dut0 (.clock(clock), .nReset(nReset), .bus(bus0.slave));
  dac_spi_tx #(.CLK_DIV(1)) u_dut1 (.clock(clock), .nReset(nReset), .bus(bus1.slave));

  int n_total = 0;
  int n_pass  = 0;

  // Expected frames per DUT, pushed when a sample that must appear is issued
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  int          done_cnt[2];
  int          ovr_cnt[2];
  int          idle_mosi_err[2];
  int          frames[2];
  int          rises[2];
  int          low_cyc[2];
  int          gap_cyc[2];
  int          last_gap[2];
  int          first_rise[2];
  int          last_rise[2];
  logic        in_frame[2];
  logic        prev_sclk[2];
  logic [15:0] bits[2];
  int          exp_low[2]  = '{132, 33};
  int          exp_span[2] = '{120, 30};

  // Pin-level decoder: rebuilds each frame and checks it against the scoreboard
  task automatic mon(input int i, input logic rstn, input logic sclk, input logic cs_n,
                     input logic mosi, input logic done, input logic ovr);
    logic [15:0] exp;
    if (!rstn) begin
      in_frame[i]  = 1'b0;
      rises[i]     = 0;
      prev_sclk[i] = 1'b0;
      gap_cyc[i]   = 0;
      return;
    end
    if (done === 1'b1) done_cnt[i]++;
    if (ovr === 1'b1) ovr_cnt[i]++;
    if (cs_n !== 1'b0) begin
      if (mosi !== 1'b0) idle_mosi_err[i]++;
      if (in_frame[i]) begin
        in_frame[i] = 1'b0;
        frames[i]++;
        gap_cyc[i] = 0;
        if (i == 0 && q0.size() == 0 || i == 1 && q1.size() == 0) begin
          n_total++;
          $display("FAIL frame_unexpected dut%0d: got %h, expected no frame", i, bits[i]);
        end else begin
          exp = (i == 0) ? q0.pop_front() : q1.pop_front();
          n_total++;
          if (bits[i] !== exp) $display("FAIL frame_data dut%0d: got %h, expected %h", i, bits[i], exp);
          else n_pass++;
          n_total++;
          if (rises[i] !== 16) $display("FAIL sclk_rises dut%0d: got %0d, expected 16", i, rises[i]);
          else n_pass++;
          n_total++;
          if (low_cyc[i] !== exp_low[i]) $display("FAIL cs_low_cycles dut%0d: got %0d, expected %0d", i, low_cyc[i], exp_low[i]);
          else n_pass++;
          n_total++;
          if (last_rise[i] - first_rise[i] !== exp_span[i])
            $display("FAIL sclk_span dut%0d: got %0d, expected %0d", i, last_rise[i] - first_rise[i], exp_span[i]);
          else n_pass++;
          n_total++;
          if (done !== 1'b1) $display("FAIL done_at_cs_rise dut%0d: got %b, expected 1", i, done);
          else n_pass++;
        end
      end
      gap_cyc[i]++;
    end else begin
      if (!in_frame[i]) begin
        in_frame[i]   = 1'b1;
        last_gap[i]   = gap_cyc[i];
        rises[i]      = 0;
        low_cyc[i]    = 0;
        bits[i]       = '0;
        first_rise[i] = -1;
        last_rise[i]  = -1;
      end
      low_cyc[i]++;
      if (sclk === 1'b1 && prev_sclk[i] === 1'b0) begin
        bits[i] = {bits[i][14:0], mosi};
        rises[i]++;
        if (first_rise[i] < 0) first_rise[i] = low_cyc[i];
        last_rise[i] = low_cyc[i];
      end
    end
    prev_sclk[i] = sclk;
  endtask

  // Sample pins mid-cycle, away from the active edge
  always @(negedge clock) begin
    mon(0, nReset, bus0.dac_sclk, bus0.dac_cs_n, bus0.dac_mosi, bus0.done, bus0.overrun);
    mon(1, nReset, bus1.dac_sclk, bus1.dac_cs_n, bus1.dac_mosi, bus1.done, bus1.overrun);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input int i, input logic [31:0] d);
    if (i == 0) begin bus0.start = 1'b1; bus0.wdata = d; end
    else        begin bus1.start = 1'b1; bus1.wdata = d; end
    tick();
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus0.wdata = $urandom();
    bus1.wdata = $urandom();
  endtask

  task automatic wait_idle(input int i, input int maxc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      if (i == 0 && !bus0.busy && q0.size() == 0) begin ok = 1'b1; break; end
      if (i == 1 && !bus1.busy && q1.size() == 0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    #1 nReset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      obs = {bus0.dac_sclk, bus0.dac_cs_n, bus0.dac_mosi, bus0.busy, bus0.done, bus0.overrun,
             bus1.dac_sclk, bus1.dac_cs_n, bus1.dac_mosi, bus1.busy, bus1.done, bus1.overrun};
      n_total++;
      if (obs !== 12'b010000_010000) $display("FAIL reset_outputs cycle %0d: got %b, expected 010000010000", c, obs);
      else n_pass++;
    end
    nReset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int d0 = done_cnt[0];
    int done_at = -1;
    int busy_fall = -1;
    q0.push_back(16'h3ABC);
    issue(0, 32'hFFFF_FABC);
    n_total++;
    if ({bus0.busy, bus0.dac_cs_n} !== 2'b10) $display("FAIL start_busy_cs: got %b, expected 10", {bus0.busy, bus0.dac_cs_n});
    else n_pass++;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (bus0.done === 1'b1 && done_at < 0) done_at = c;
      if (done_at >= 0 && bus0.busy === 1'b0) begin busy_fall = c; break; end
    end
    n_total++;
    if (done_at < 0 || busy_fall < 0 || busy_fall - done_at != 4)
      $display("FAIL busy_after_done: got done@%0d busy_fall@%0d, expected gap 4", done_at, busy_fall);
    else n_pass++;
    tick();
    n_total++;
    if (done_cnt[0] - d0 != 1 || q0.size() != 0)
      $display("FAIL single_done_count: got %0d pulses, %0d queued, expected 1 and 0", done_cnt[0] - d0, q0.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int f0 = frames[0];
    int o0 = ovr_cnt[0];
    q0.push_back(16'h3123);
    q0.push_back(16'h3456);
    issue(0, 32'h0000_0123);
    repeat (9) tick();
    issue(0, 32'h0000_0456);
    n_total++;
    if (bus0.overrun !== 1'b0) $display("FAIL b2b_no_overrun_pulse: got %b, expected 0", bus0.overrun);
    else n_pass++;
    wait_idle(0, 700, ok);
    n_total++;
    if (!ok) $display("FAIL b2b_timeout: got busy=%b queued=%0d, expected idle", bus0.busy, q0.size());
    else n_pass++;
    n_total++;
    if (frames[0] - f0 != 2) $display("FAIL b2b_frames: got %0d, expected 2", frames[0] - f0);
    else n_pass++;
    n_total++;
    if (last_gap[0] != 4) $display("FAIL b2b_gap: got %0d, expected 4", last_gap[0]);
    else n_pass++;
    n_total++;
    if (ovr_cnt[0] != o0) $display("FAIL b2b_overrun: got %0d, expected 0", ovr_cnt[0] - o0);
    else n_pass++;
  endtask

  task automatic test_overrun();
    bit ok;
    int f0 = frames[0];
    int o0 = ovr_cnt[0];
    q0.push_back(16'h3111);
    q0.push_back(16'h3333);
    issue(0, 32'h0000_0111);
    repeat (5) tick();
    issue(0, 32'h0000_0222);
    n_total++;
    if (bus0.overrun !== 1'b0) $display("FAIL overrun_second: got %b, expected 0", bus0.overrun);
    else n_pass++;
    repeat (5) tick();
    issue(0, 32'h0000_0333);
    n_total++;
    if (bus0.overrun !== 1'b1) $display("FAIL overrun_third: got %b, expected 1", bus0.overrun);
    else n_pass++;
    tick();
    n_total++;
    if (bus0.overrun !== 1'b0) $display("FAIL overrun_width: got %b, expected 0", bus0.overrun);
    else n_pass++;
    wait_idle(0, 700, ok);
    n_total++;
    if (!ok || frames[0] - f0 != 2 || ovr_cnt[0] - o0 != 1)
      $display("FAIL overrun_totals: got ok=%b frames=%0d overruns=%0d, expected 1/2/1", ok, frames[0] - f0, ovr_cnt[0] - o0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit reached = 1'b0;
    int f0 = frames[0];
    int d0 = done_cnt[0];
    issue(0, 32'h0000_0777);
    for (int c = 0; c < 300; c++) begin
      if (rises[0] >= 7) begin reached = 1'b1; break; end
      tick();
    end
    n_total++;
    if (!reached) $display("FAIL reset_mid_reach: got %0d rises, expected 7", rises[0]);
    else n_pass++;
    nReset = 1'b0;
    #1;
    n_total++;
    if ({bus0.dac_cs_n, bus0.dac_sclk, bus0.busy} !== 3'b100)
      $display("FAIL reset_mid_pins: got %b, expected 100", {bus0.dac_cs_n, bus0.dac_sclk, bus0.busy});
    else n_pass++;
    repeat (3) tick();
    nReset = 1'b1;
    repeat (2) tick();
    n_total++;
    if (done_cnt[0] != d0 || frames[0] != f0)
      $display("FAIL reset_mid_discard: got done=%0d frames=%0d, expected 0 and 0", done_cnt[0] - d0, frames[0] - f0);
    else n_pass++;
    q0.push_back(16'h3BCD);
    issue(0, 32'h0000_0BCD);
    wait_idle(0, 400, ok);
    n_total++;
    if (!ok || frames[0] - f0 != 1) $display("FAIL reset_mid_recover: got ok=%b frames=%0d, expected 1/1", ok, frames[0] - f0);
    else n_pass++;
  endtask

  task automatic test_clkdiv1();
    bit ok;
    int f1 = frames[1];
    q1.push_back(16'h3A5A);
    issue(1, 32'h0000_0A5A);
    wait_idle(1, 200, ok);
    n_total++;
    if (!ok || frames[1] - f1 != 1) $display("FAIL div1_frame: got ok=%b frames=%0d, expected 1/1", ok, frames[1] - f1);
    else n_pass++;
  endtask

  task automatic test_idle_mosi();
    n_total++;
    if (idle_mosi_err[0] != 0 || idle_mosi_err[1] != 0)
      $display("FAIL idle_mosi: got %0d/%0d samples with mosi high, expected 0", idle_mosi_err[0], idle_mosi_err[1]);
    else n_pass++;
  endtask

  initial begin
    bus0.start = 1'b0;
    bus0.wdata = '0;
    bus1.start = 1'b0;
    bus1.wdata = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_clkdiv1();
    test_idle_mosi();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
